// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, owner hold and optional tenure limit.
// Build macro RR_ARB_HOLD_TIMEOUT_EN enables the MAX_HOLD tenure timeout.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDW-1:0]     gnt_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject out-of-range configurations at elaboration time.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
            $error("rr_arbiter: NUM_REQ must be in 2..16");
        end
        if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
            $error("rr_arbiter: MAX_HOLD must be in 2..256");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [IDW-1:0]     owner_reg, owner_next;
    logic [IDW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic               gnt_valid_reg, gnt_valid_next;
    logic [NUM_REQ-1:0] owner_decode;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic               take_new;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD);
    logic [HCW-1:0]     hold_cnt_reg, hold_cnt_next;
`endif

    // Index arithmetic modulo NUM_REQ; base is always < NUM_REQ and off <= NUM_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDW'(sum);
    endfunction

    // Winner is the first asserted request scanning upward from rr_ptr with wrap.
    // Because rr_ptr is always owner+1 during a tenure, a timed-out owner is scanned last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!win_found && req[wrap_add(rr_ptr_reg, off)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr_reg, off);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        gnt_valid_next = gnt_valid_reg;
        take_new       = 1'b0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        hold_cnt_next  = hold_cnt_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (win_found) begin
                    take_new = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_reg]) begin
                    if (win_found) begin
                        take_new = 1'b1;
                    end else begin
                        state_next     = IDLE;
                        owner_next     = '0;
                        gnt_valid_next = 1'b0;
                    end
                end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                else if (hold_cnt_reg == HCW'(MAX_HOLD - 1)) begin
                    take_new = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
`endif
            end
            default: begin
                state_next     = IDLE;
                owner_next     = '0;
                gnt_valid_next = 1'b0;
            end
        endcase

        if (take_new) begin
            state_next     = GRANT;
            owner_next     = win_idx;
            rr_ptr_next    = wrap_add(win_idx, 1);
            gnt_valid_next = 1'b1;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt_next  = '0;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
            assign owner_decode[gi] = (owner_next == IDW'(gi));
        end
    endgenerate

    assign gnt_next = gnt_valid_next ? owner_decode : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt_reg  <= hold_cnt_next;
`endif
        end
    end

    // owner_reg is forced to zero whenever no grant is active, so it doubles as gnt_id.
    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign gnt_id    = owner_reg;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per tenure; legal range 2..256.
REQ-003 Port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port req, input, NUM_REQ, request vector; bit i is requester i.
REQ-006 Port gnt, output, NUM_REQ, registered one-hot grant, or all zero.
REQ-007 Port gnt_valid, output, 1, registered; equals OR of gnt.
REQ-008 Port gnt_id, output, IDW = max(1, clog2(NUM_REQ)), registered binary index of the granted requester; 0 when gnt_valid=0.

Function
REQ-009 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-010 Grant latency SHALL be one cycle: req sampled at edge k is reflected on gnt after edge k.
REQ-011 Arbitration SHALL be round-robin: the winner is the first asserted req bit at or above rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-012 On every new grant to index w, rr_ptr SHALL become (w+1) mod NUM_REQ; rr_ptr SHALL NOT change otherwise.
REQ-013 IDLE with req=0 SHALL remain IDLE with gnt=0; IDLE with req!=0 SHALL grant the winner and enter GRANT with hold_cnt=0.
REQ-014 In GRANT, while req[owner]=1 and no timeout applies, gnt SHALL hold unchanged and hold_cnt SHALL increment by 1 per cycle.
REQ-015 In GRANT, when req[owner]=0 at an edge, the block SHALL re-arbitrate in that same edge: grant the winner among the remaining requests with no idle cycle, or return to IDLE with gnt=0 if none.
REQ-016 Requests from non-owners SHALL never pre-empt an owner except through the timeout in REQ-021.
REQ-017 gnt SHALL never have more than one bit set; gnt, gnt_valid and gnt_id SHALL change only at clock edges.
REQ-018 The block SHALL not generate combinational paths from req to any output.

Reset
REQ-019 When reset=1 at an edge: gnt=0, gnt_valid=0, gnt_id=0, rr_ptr=0, hold_cnt=0, state=IDLE; reset has priority over all other events.
REQ-020 Reset asserted mid-tenure SHALL drop the grant at that edge; the first grant after reset deasserts SHALL be arbitrated from rr_ptr=0.

Configuration
REQ-021 With macro RR_ARB_HOLD_TIMEOUT_EN defined: when hold_cnt=MAX_HOLD-1 and req[owner]=1 at an edge, the block SHALL re-arbitrate from rr_ptr (owner+1), re-granting the same owner with hold_cnt=0 only if no other req bit is set; the tenure is thus exactly MAX_HOLD cycles under contention.
REQ-022 Without RR_ARB_HOLD_TIMEOUT_EN: hold_cnt and MAX_HOLD SHALL be unused, and an owner SHALL keep its grant as long as its req stays 1.

Verification (NUM_REQ=4, MAX_HOLD=4)
REQ-023 Reset: reset=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0 at every edge while reset=1.
REQ-024 Single requester: req=4'b0100 from IDLE -> gnt=4'b0100, gnt_id=2 one cycle later; req drop -> gnt=0 at the next edge.
REQ-025 Handoff: owner 0 holding, req=4'b0101 then req[0] drops -> next edge gnt=4'b0100 with no zero cycle between grants.
REQ-026 Timeout (macro defined): req=4'b1111 held after reset -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001...; lone req=4'b0001 -> gnt stays 4'b0001 indefinitely.
REQ-027 No timeout (macro undefined): req=4'b1111 held after reset -> gnt=4'b0001 for 20+ cycles; req[0] drop -> gnt=4'b0010 next edge.
REQ-028 Reset mid-grant: owner 3 holding, reset=1 one cycle with req=4'b1010 -> gnt=0 at that edge; after release gnt=4'b0010 (rr_ptr=0).
